// File: rtl/shift_pipe.sv
// Pipelined ARM-style barrel shifter (LSL/LSR/ASR/ROR/RRX) with carry-out and valid/ready
// flow control on both sides; mux levels are spread evenly over STAGES register stages.
module shift_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned AMT_W  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [2:0]       in_op,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_cout
);

    localparam int unsigned LW   = $clog2(WIDTH);
    localparam int unsigned Last = STAGES - 1;
    localparam int unsigned CtlN = (STAGES > 1) ? STAGES - 1 : 1;
    localparam logic [AMT_W-1:0] WAmt = AMT_W'(WIDTH);

    localparam logic [2:0] OpLsl = 3'b000;
    localparam logic [2:0] OpLsr = 3'b001;
    localparam logic [2:0] OpAsr = 3'b010;
    localparam logic [2:0] OpRor = 3'b011;
    localparam logic [2:0] OpRrx = 3'b100;

    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            r[i] = x[WIDTH-1-i];
        end
        return r;
    endfunction

    // Right-shift (rotate or fill) by the amount bits owned by the given stage.
    function automatic logic [WIDTH-1:0] run_levels(input logic [WIDTH-1:0] x,
                                                    input logic [LW-1:0] sh,
                                                    input logic rot, input logic fill,
                                                    input int unsigned stage);
        logic [WIDTH-1:0] y;
        y = x;
        for (int unsigned k = 0; k < LW; k++) begin
            if ((k * STAGES) / LW == stage && sh[k]) begin
                if (rot) y = (y >> (1 << k)) | (y << (WIDTH - (1 << k)));
                else     y = (y >> (1 << k)) | ({WIDTH{fill}} << (WIDTH - (1 << k)));
            end
        end
        return y;
    endfunction

    // Stage-0 decode: everything becomes a right shift; LSL runs on the bit-reversed operand.
    logic [LW-1:0]    amt_lo, amt_m1, amt_neg;
    logic             amt_zero, amt_lt_w, amt_eq_w;
    logic [WIDTH-1:0] dec_data;
    logic [LW-1:0]    dec_sh;
    logic             dec_rot, dec_fill, dec_rev, dec_sat, dec_cout;

    assign amt_lo   = in_amt[LW-1:0];
    assign amt_m1   = amt_lo - LW'(1);
    assign amt_neg  = ~amt_lo + LW'(1);
    assign amt_zero = (in_amt == '0);
    assign amt_lt_w = (in_amt < WAmt);
    assign amt_eq_w = (in_amt == WAmt);

    always_comb begin
        dec_sh   = '0;
        dec_rot  = 1'b0;
        dec_fill = 1'b0;
        dec_rev  = 1'b0;
        dec_sat  = 1'b0;
        dec_cout = in_cin;
        case (in_op)
            OpLsl: begin
                dec_rev = 1'b1;
                if (!amt_zero) begin
                    if (amt_lt_w) begin
                        dec_sh   = amt_lo;
                        dec_cout = in_data[amt_neg];
                    end else begin
                        dec_sat  = 1'b1;
                        dec_cout = amt_eq_w ? in_data[0] : 1'b0;
                    end
                end
            end
            OpLsr: begin
                if (!amt_zero) begin
                    if (amt_lt_w) begin
                        dec_sh   = amt_lo;
                        dec_cout = in_data[amt_m1];
                    end else begin
                        dec_sat  = 1'b1;
                        dec_cout = amt_eq_w ? in_data[WIDTH-1] : 1'b0;
                    end
                end
            end
            OpAsr: begin
                dec_fill = in_data[WIDTH-1];
                if (!amt_zero) begin
                    if (amt_lt_w) begin
                        dec_sh   = amt_lo;
                        dec_cout = in_data[amt_m1];
                    end else begin
                        dec_sat  = 1'b1;
                        dec_cout = in_data[WIDTH-1];
                    end
                end
            end
            OpRor: begin
                if (!amt_zero) begin
                    dec_rot  = 1'b1;
                    dec_sh   = amt_lo;
                    dec_cout = in_data[amt_m1];
                end
            end
            OpRrx: begin
                dec_sh   = LW'(1);
                dec_fill = in_cin;
                dec_cout = in_data[0];
            end
            default: ;
        endcase
        if (dec_sat)      dec_data = {WIDTH{dec_fill}};
        else if (dec_rev) dec_data = bit_rev(in_data);
        else              dec_data = in_data;
    end

    logic [STAGES-1:0] valid_q, ready, take, ld_valid;
    logic [WIDTH-1:0]  data_q  [STAGES];
    logic [WIDTH-1:0]  ld_data [STAGES];
    logic [STAGES-1:0] cout_q, ld_cout;
    logic [LW-1:0]     sh_q    [CtlN];
    logic [LW-1:0]     ld_sh   [CtlN];
    logic [CtlN-1:0]   rot_q, fill_q, rev_q, ld_rot, ld_fill, ld_rev;

    // A stage can load when empty or when its occupant moves on this cycle.
    always_comb begin
        logic nxt;
        nxt = out_ready;
        for (int s = STAGES - 1; s >= 0; s--) begin
            ready[s] = !valid_q[s] || nxt;
            nxt      = ready[s];
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic [WIDTH-1:0] src_data, lvl_data;
        logic [LW-1:0]    src_sh;
        logic             src_rot, src_fill, src_rev, src_cout, src_valid;

        if (s == 0) begin : g_first
            assign src_data  = dec_data;
            assign src_sh    = dec_sh;
            assign src_rot   = dec_rot;
            assign src_fill  = dec_fill;
            assign src_rev   = dec_rev;
            assign src_cout  = dec_cout;
            assign src_valid = in_valid;
        end else begin : g_rest
            assign src_data  = data_q[s-1];
            assign src_sh    = sh_q[s-1];
            assign src_rot   = rot_q[s-1];
            assign src_fill  = fill_q[s-1];
            assign src_rev   = rev_q[s-1];
            assign src_cout  = cout_q[s-1];
            assign src_valid = valid_q[s-1];
        end

        assign lvl_data    = run_levels(src_data, src_sh, src_rot, src_fill, s);
        assign ld_data[s]  = (s == Last && src_rev) ? bit_rev(lvl_data) : lvl_data;
        assign ld_cout[s]  = src_cout;
        assign ld_valid[s] = src_valid;
        assign take[s]     = ready[s] && src_valid;

        if (s < Last) begin : g_ctl
            assign ld_sh[s]   = src_sh;
            assign ld_rot[s]  = src_rot;
            assign ld_fill[s] = src_fill;
            assign ld_rev[s]  = src_rev;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            cout_q  <= '0;
            rot_q   <= '0;
            fill_q  <= '0;
            rev_q   <= '0;
            for (int s = 0; s < STAGES; s++) data_q[s] <= '0;
            for (int s = 0; s < CtlN; s++)   sh_q[s]   <= '0;
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (ready[s]) valid_q[s] <= ld_valid[s];
                if (take[s]) begin
                    data_q[s] <= ld_data[s];
                    cout_q[s] <= ld_cout[s];
                end
            end
            for (int s = 0; s < STAGES - 1; s++) begin
                if (take[s]) begin
                    sh_q[s]   <= ld_sh[s];
                    rot_q[s]  <= ld_rot[s];
                    fill_q[s] <= ld_fill[s];
                    rev_q[s]  <= ld_rev[s];
                end
            end
        end
    end

    assign in_ready  = ready[0];
    assign out_valid = valid_q[Last];
    assign out_data  = data_q[Last];
    assign out_cout  = cout_q[Last];

endmodule

// File: tb/tb_shift_pipe.sv
// Scoreboard bench for shift_pipe: expected results queued at acceptance, checked at retirement.
module tb_shift_pipe;

    localparam int unsigned W  = 32;
    localparam int unsigned AW = 8;
    localparam int unsigned ST = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_ready, in_cin, out_valid, out_ready, out_cout;
    logic [W-1:0]  in_data, out_data;
    logic [AW-1:0] in_amt;
    logic [2:0]    in_op;

    shift_pipe #(.WIDTH(W), .AMT_W(AW), .STAGES(ST)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_amt(in_amt),
        .in_op(in_op), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_cout(out_cout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] d;
        logic         c;
    } exp_t;

    typedef struct {
        logic [W-1:0]  a;
        logic [AW-1:0] n;
        logic [2:0]    op;
        logic          c;
        logic [W-1:0]  ed;
        logic          ec;
    } vec_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    logic         s_acc, s_ret, s_ov, s_ir, s_cout;
    logic [W-1:0] s_data;

    function automatic exp_t ref_model(input logic [W-1:0] a, input logic [AW-1:0] n,
                                       input logic [2:0] op, input logic c);
        exp_t         r;
        int           nn, rr;
        logic [W-1:0] t;
        nn = int'(n);
        r  = {a, c};
        case (op)
            3'b000: if (nn > 0 && nn < W) r = {a << nn, a[W-nn]};
                    else if (nn == W)     r = {{W{1'b0}}, a[0]};
                    else if (nn > W)      r = {{W{1'b0}}, 1'b0};
            3'b001: if (nn > 0 && nn < W) r = {a >> nn, a[nn-1]};
                    else if (nn == W)     r = {{W{1'b0}}, a[W-1]};
                    else if (nn > W)      r = {{W{1'b0}}, 1'b0};
            3'b010: if (nn > 0 && nn < W) begin
                        t = W'($signed(a) >>> nn);
                        r = {t, a[nn-1]};
                    end else if (nn >= W) r = {{W{a[W-1]}}, a[W-1]};
            3'b011: if (nn > 0) begin
                        rr = nn % W;
                        if (rr == 0) r = {a, a[W-1]};
                        else begin
                            t = (a >> rr) | (a << (W - rr));
                            r = {t, t[W-1]};
                        end
                    end
            3'b100: r = {{c, a[W-1:1]}, a[0]};
            default: r = {a, c};
        endcase
        return r;
    endfunction

    // One clock: drive at negedge, sample mid-cycle, return at the following rising edge.
    task automatic tick(input logic iv, input logic [W-1:0] a, input logic [AW-1:0] n,
                        input logic [2:0] op, input logic c, input logic ordy);
        @(negedge clk);
        in_valid  = iv;
        in_data   = a;
        in_amt    = n;
        in_op     = op;
        in_cin    = c;
        out_ready = ordy;
        #1;
        s_acc  = in_valid && in_ready;
        s_ret  = out_valid && out_ready;
        s_ov   = out_valid;
        s_ir   = in_ready;
        s_data = out_data;
        s_cout = out_cout;
        @(posedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total += 4;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", in_ready); end
        if (out_data !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", out_data); end
        if (out_cout !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b want=0", out_cout); end
        reset = 1'b0;
    endtask

    task automatic test_first_lsl();
        exp_t e;
        int   cyc = 0;
        bit   got = 0;
        tick(1'b1, 32'h8000_0001, 8'd1, 3'b000, 1'b0, 1'b1);
        total++;
        if (!s_acc) begin bad++; $display("FAIL first_accept got=0 want=1"); end
        else sb.push_back({32'h0000_0002, 1'b1});
        while (!got && cyc < 10) begin
            tick(1'b0, '0, '0, 3'b000, 1'b0, 1'b1);
            cyc++;
            if (s_ret) begin
                got = 1;
                e = sb.pop_front();
                total += 3;
                if (cyc != ST) begin bad++; $display("FAIL first_latency got=%0d want=%0d", cyc, ST); end
                if (s_data !== e.d) begin bad++; $display("FAIL first_data got=%h want=%h", s_data, e.d); end
                if (s_cout !== e.c) begin bad++; $display("FAIL first_cout got=%b want=%b", s_cout, e.c); end
            end
        end
        if (!got) begin total++; bad++; $display("FAIL first_timeout got=none want=result"); end
    endtask

    task automatic test_vectors();
        vec_t v[8];
        exp_t e;
        int   idx = 0;
        int   ret = 0;
        v[0] = '{32'h8000_0001, 8'd32, 3'b001, 1'b0, 32'h0000_0000, 1'b1};
        v[1] = '{32'h8000_0001, 8'd33, 3'b001, 1'b0, 32'h0000_0000, 1'b0};
        v[2] = '{32'h8000_0001, 8'd40, 3'b010, 1'b0, 32'hFFFF_FFFF, 1'b1};
        v[3] = '{32'h8000_0001, 8'd0,  3'b000, 1'b1, 32'h8000_0001, 1'b1};
        v[4] = '{32'h0000_00F1, 8'd4,  3'b011, 1'b0, 32'h1000_000F, 1'b0};
        v[5] = '{32'h0000_00F1, 8'd64, 3'b011, 1'b0, 32'h0000_00F1, 1'b0};
        v[6] = '{32'h0000_00F1, 8'd9,  3'b100, 1'b1, 32'h8000_0078, 1'b1};
        v[7] = '{32'h0000_00F1, 8'd3,  3'b111, 1'b1, 32'h0000_00F1, 1'b1};
        for (int cyc = 0; cyc < 60 && ret < 8; cyc++) begin
            if (idx < 8) tick(1'b1, v[idx].a, v[idx].n, v[idx].op, v[idx].c, 1'b1);
            else         tick(1'b0, '0, '0, 3'b000, 1'b0, 1'b1);
            if (s_ret) begin
                total++;
                if (sb.size() == 0) begin bad++; $display("FAIL vec_extra got=result want=none"); end
                else begin
                    e = sb.pop_front();
                    if (s_data !== e.d || s_cout !== e.c) begin
                        bad++;
                        $display("FAIL vec%0d got=%h/%b want=%h/%b", ret, s_data, s_cout, e.d, e.c);
                    end
                end
                ret++;
            end
            if (s_acc) begin
                sb.push_back({v[idx].ed, v[idx].ec});
                idx++;
            end
        end
        total++;
        if (ret != 8) begin bad++; $display("FAIL vec_count got=%0d want=8", ret); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0]  ca = '0;
        logic [AW-1:0] cn = '0;
        logic [2:0]    cop = '0;
        logic          cc = 1'b0, have = 1'b0, ordy, stall_prev = 1'b0, prev_c = 1'b0, exp_ir;
        logic [W-1:0]  prev_d = '0;
        exp_t          e;
        int            sent = 0, ret = 0, occ = 0;
        sb.delete();
        for (int cyc = 0; cyc < 500 && ret < 8; cyc++) begin
            if (!have && sent < 8 && $urandom_range(0, 3) != 0) begin
                ca   = $urandom();
                cn   = AW'($urandom_range(0, 70));
                cop  = 3'($urandom_range(0, 7));
                cc   = 1'($urandom_range(0, 1));
                have = 1'b1;
            end
            ordy = 1'($urandom_range(0, 1));
            tick(have, ca, cn, cop, cc, ordy);
            if (stall_prev) begin
                total++;
                if (!s_ov || s_data !== prev_d || s_cout !== prev_c) begin
                    bad++;
                    $display("FAIL bp_hold got=%b/%h/%b want=1/%h/%b", s_ov, s_data, s_cout, prev_d, prev_c);
                end
            end
            exp_ir = !(occ == ST && !ordy);
            total++;
            if (s_ir !== exp_ir) begin
                bad++;
                $display("FAIL bp_in_ready got=%b want=%b occ=%0d", s_ir, exp_ir, occ);
            end
            if (s_ret) begin
                total++;
                if (sb.size() == 0) begin bad++; $display("FAIL bp_extra got=result want=none"); end
                else begin
                    e = sb.pop_front();
                    if (s_data !== e.d || s_cout !== e.c) begin
                        bad++;
                        $display("FAIL bp%0d got=%h/%b want=%h/%b", ret, s_data, s_cout, e.d, e.c);
                    end
                end
                ret++;
            end
            if (s_acc) begin
                sb.push_back(ref_model(ca, cn, cop, cc));
                sent++;
                have = 1'b0;
            end
            occ        = occ + int'(s_acc) - int'(s_ret);
            stall_prev = s_ov && !ordy;
            prev_d     = s_data;
            prev_c     = s_cout;
        end
        total++;
        if (ret != 8 || sb.size() != 0) begin
            bad++;
            $display("FAIL bp_count got=%0d left=%0d want=8 left=0", ret, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]  a;
        logic [AW-1:0] n;
        logic [2:0]    op;
        logic          c;
        exp_t          e;
        int            sent = 0, ret = 0, first = -1, last = -1;
        sb.delete();
        for (int cyc = 0; cyc < 60 && ret < 16; cyc++) begin
            a  = $urandom();
            n  = AW'($urandom_range(0, 40));
            op = 3'($urandom_range(0, 4));
            c  = 1'($urandom_range(0, 1));
            tick(sent < 16, a, n, op, c, 1'b1);
            if (sent < 16) begin
                total++;
                if (s_ir !== 1'b1) begin bad++; $display("FAIL b2b_ready cyc=%0d got=%b want=1", cyc, s_ir); end
            end
            if (s_ret) begin
                total++;
                if (first < 0) first = cyc;
                last = cyc;
                if (sb.size() == 0) begin bad++; $display("FAIL b2b_extra got=result want=none"); end
                else begin
                    e = sb.pop_front();
                    if (s_data !== e.d || s_cout !== e.c) begin
                        bad++;
                        $display("FAIL b2b%0d got=%h/%b want=%h/%b", ret, s_data, s_cout, e.d, e.c);
                    end
                end
                ret++;
            end
            if (s_acc) begin
                sb.push_back(ref_model(a, n, op, c));
                sent++;
            end
        end
        total += 2;
        if (first != ST) begin bad++; $display("FAIL b2b_fill got=%0d want=%0d", first, ST); end
        if (ret != 16 || last - first != 15) begin
            bad++;
            $display("FAIL b2b_gapless got=%0d/%0d want=16/15", ret, last - first);
        end
    endtask

    task automatic test_reset_flight();
        exp_t e;
        int   stray = 0;
        bit   got = 0;
        sb.delete();
        tick(1'b1, 32'h1234_5678, 8'd3, 3'b001, 1'b0, 1'b0);
        tick(1'b1, 32'h8765_4321, 8'd5, 3'b000, 1'b0, 1'b0);
        tick(1'b0, '0, '0, 3'b000, 1'b0, 1'b0);
        total++;
        if (s_ov !== 1'b1) begin bad++; $display("FAIL flight_pre got=%b want=1", s_ov); end
        #2 reset = 1'b1;
        #1;
        total += 2;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL flight_async got=%b want=0", out_valid); end
        if (in_ready !== 1'b1) begin bad++; $display("FAIL flight_ready got=%b want=1", in_ready); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) begin
            tick(1'b0, '0, '0, 3'b000, 1'b0, 1'b1);
            if (s_ov) stray++;
        end
        total++;
        if (stray != 0) begin bad++; $display("FAIL flight_stale got=%0d want=0", stray); end
        tick(1'b1, 32'h0000_00F8, 8'd4, 3'b001, 1'b0, 1'b1);
        if (s_acc) sb.push_back({32'h0000_000F, 1'b1});
        for (int cyc = 0; cyc < 10 && !got; cyc++) begin
            tick(1'b0, '0, '0, 3'b000, 1'b0, 1'b1);
            if (s_ret) begin
                got = 1;
                total++;
                if (sb.size() == 0) begin bad++; $display("FAIL flight_extra got=result want=none"); end
                else begin
                    e = sb.pop_front();
                    if (s_data !== e.d || s_cout !== e.c) begin
                        bad++;
                        $display("FAIL flight_next got=%h/%b want=%h/%b", s_data, s_cout, e.d, e.c);
                    end
                end
            end
        end
        if (!got) begin total++; bad++; $display("FAIL flight_timeout got=none want=result"); end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_op     = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_first_lsl();
        test_vectors();
        test_backpressure();
        test_back_to_back();
        test_reset_flight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/shift_pipe.md
# shift_pipe

Parametrised, pipelined barrel shifter for the datapath's register-shifted operand path. It implements ARM shift semantics (LSL, LSR, ASR, ROR, RRX) with a shifter carry-out and full amount-range handling (amount 0, equal to WIDTH, beyond WIDTH). Sits between register-file read and the ALU operand-B mux. Valid/ready handshakes on both sides let a multi-cycle shift stall cleanly under back-pressure.

## Interface
- WIDTH, 32, data width; power of two, 8..64
- AMT_W, 8, shift-amount width; must be >= log2(WIDTH)+1
- STAGES, 2, register stages from input to output, 1..log2(WIDTH)
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all pipeline state
- in_valid  input  1  operand presented
- in_ready  output  1  operand accepted when in_valid && in_ready
- in_data  input  WIDTH  value to shift
- in_amt  input  AMT_W  unsigned shift amount
- in_op  input  3  000 LSL, 001 LSR, 010 ASR, 011 ROR, 100 RRX, others pass-through
- in_cin  input  1  current C flag
- out_valid  output  1  result held
- out_ready  input  1  result consumed when out_valid && out_ready
- out_data  output  WIDTH  shifted result
- out_cout  output  1  shifter carry-out

## Operation
- Let a = in_data, n = in_amt, W = WIDTH, c = in_cin.
- n == 0 for LSL/LSR/ASR/ROR: result a, cout c.
- LSL: 1<=n<W gives a<<n, cout a[W-n]. n==W gives 0, cout a[0]. n>W gives 0, cout 0.
- LSR: 1<=n<W gives a>>n, cout a[n-1]. n==W gives 0, cout a[W-1]. n>W gives 0, cout 0.
- ASR: 1<=n<W gives arithmetic shift, cout a[n-1]. n>=W gives all bits a[W-1], cout a[W-1].
- ROR, n != 0:
  - r = n mod W.
  - r == 0 gives result a, cout a[W-1].
  - Otherwise result is a rotated right by r, cout = result[W-1].
- RRX: result {c, a[W-1:1]}, cout a[0]; n ignored.
- Ops 101/110/111: result a, cout c.
- Amount decode (clamp/modulo, saturation flags) happens in stage 0.
- The log2(W) mux levels are split as evenly as possible across STAGES. Only the register count is architecturally visible.
- Each stage holds a valid bit plus payload (data, partial amount, op, cin, sign, carry candidates).
- A stage loads when it is empty or its contents advance in the same cycle.
- in_ready = !v0 || advancing0, combinational from valid bits and out_ready. It never depends on in_valid.
- No reordering, drop or duplication: results emerge in acceptance order, one per handshake.
- Payload registers of empty stages are don't-care, except out_data/out_cout, which hold the last value until replaced.

## Timing
- Reset (async assert, sync-safe release):
  - all valid bits 0, so out_valid = 0 and in_ready = 1;
  - out_data = 0, out_cout = 0.
- Latency: an operand accepted at edge k gives out_valid = 1 after edge k+STAGES-1, i.e. visible in the cycle following edge k+STAGES-1.
- Minimum latency is STAGES cycles from the in_valid cycle to the out_valid cycle.
- Throughput is 1 per cycle while out_ready = 1.
- out_ready = 0 with out_valid = 1:
  - out_data and out_cout are held stable;
  - bubbles ahead are collapsed;
  - once all STAGES are full, in_ready = 0.
- Full pipeline with out_ready = 1 and in_valid = 1 in the same cycle: accept and retire together, and occupancy is unchanged.
- in_valid deasserted mid-stream inserts a bubble only. No output is produced for it.
- out_valid may be low while out_ready is high; nothing is consumed.
- Reset mid-operation: all in-flight operands are discarded. No partial result is ever presented.

## Test plan
- Reset, then LSL a=0x8000_0001, n=1, c=0 -> out 0x0000_0002, cout 1, out_valid exactly STAGES cycles after the in_valid cycle.
- Boundaries at W=32, a=0x8000_0001:
  - LSR n=32 -> 0, cout 1;
  - LSR n=33 -> 0, cout 0;
  - ASR n=40 -> 0xFFFF_FFFF, cout 1;
  - LSL n=0, c=1 -> 0x8000_0001, cout 1.
- Rotates, a=0x0000_00F1:
  - ROR n=4 -> 0x1000_000F, cout 0;
  - ROR n=64 -> unchanged, cout 0;
  - RRX c=1 -> 0x8000_0078, cout 1;
  - op 111 -> pass-through.
- Back-pressure:
  - stream 8 random ops with out_ready toggling 0/1 randomly;
  - results match the reference model in order, none lost or duplicated;
  - out_data stable while stalled;
  - in_ready = 0 only when STAGES entries are held.
- Back-to-back: 16 ops with in_valid and out_ready tied 1 -> one result per cycle after fill, no bubbles.
- Assert reset with 2 operands in flight -> out_valid falls immediately (asynchronously). No stale result appears after release. The next op completes normally.
